// File: rtl/pe_array_ctrl_if.sv
// rtl/pe_array_ctrl_if.sv - command, A/B memory, PE and result signal bundle for pe_array_ctrl
interface pe_array_ctrl_if #(
  parameter int P           = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 2*DATA_WIDTH,
  parameter int AW          = (P*P > 1) ? $clog2(P*P) : 1
);
  localparam int IW = (P > 1) ? $clog2(P) : 1;

  logic                          start;
  logic                          abort;
  logic                          busy;
  logic                          done;
  logic                          err;
  logic                          a_rd_en;
  logic [IW-1:0]                 a_rd_addr;
  logic                          b_rd_en;
  logic [AW-1:0]                 b_rd_addr;
  logic signed [DATA_WIDTH-1:0]  b_rd_data;
  logic                          pe_load_row;
  logic                          pe_start;
  logic signed [DATA_WIDTH-1:0]  pe_col_entry;
  logic                          pe_done;
  logic                          pe_err;
  logic signed [ACCUM_WIDTH-1:0] pe_total;
  logic                          c_valid;
  logic                          c_ready;
  logic signed [ACCUM_WIDTH-1:0] c_data;
  logic [IW-1:0]                 c_row;
  logic [IW-1:0]                 c_col;

  modport master (
    input  start, abort, b_rd_data, pe_done, pe_err, pe_total, c_ready,
    output busy, done, err, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
           pe_load_row, pe_start, pe_col_entry, c_valid, c_data, c_row, c_col
  );

  modport slave (
    output start, abort, b_rd_data, pe_done, pe_err, pe_total, c_ready,
    input  busy, done, err, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
           pe_load_row, pe_start, pe_col_entry, c_valid, c_data, c_row, c_col
  );
endinterface

// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - sequences one PE row over a P x P matrix product C = A*B, row-major
module pe_array_ctrl #(
  parameter int P           = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 2*DATA_WIDTH,
  parameter int AW          = (P*P > 1) ? $clog2(P*P) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  pe_array_ctrl_if.master bus
);
  localparam int IW = (P > 1) ? $clog2(P) : 1;
  localparam logic [IW-1:0] LAST = IW'(P-1);

  typedef enum logic [2:0] {IDLE, LDREQ, LOAD, START, STREAM, WAIT, OUT} state_e;

  state_e                        state_q, state_d;
  logic [IW-1:0]                 i_q, i_d, j_q, j_d, s_q, s_d;
  logic                          err_q, err_d, done_q, done_d;
  logic signed [ACCUM_WIDTH-1:0] c_data_q, c_data_d;
  logic [IW-1:0]                 c_row_q, c_row_d, c_col_q, c_col_d;

  logic                          a_rd_en, b_rd_en, pe_load_row, pe_start, c_valid;
  logic [IW-1:0]                 a_rd_addr;
  logic [AW-1:0]                 b_rd_addr;
  logic signed [DATA_WIDTH-1:0]  pe_col_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      s_q      <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      c_data_q <= '0;
      c_row_q  <= '0;
      c_col_q  <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      s_q      <= s_d;
      err_q    <= err_d;
      done_q   <= done_d;
      c_data_q <= c_data_d;
      c_row_q  <= c_row_d;
      c_col_q  <= c_col_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    s_d          = s_q;
    done_d       = 1'b0;
    err_d        = err_q | (bus.pe_err && (state_q != IDLE));
    c_data_d     = c_data_q;
    c_row_d      = c_row_q;
    c_col_d      = c_col_q;
    a_rd_en      = 1'b0;
    a_rd_addr    = '0;
    b_rd_en      = 1'b0;
    b_rd_addr    = '0;
    pe_load_row  = 1'b0;
    pe_start     = 1'b0;
    pe_col_entry = '0;
    c_valid      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          i_d     = '0;
          j_d     = '0;
          err_d   = 1'b0;
          state_d = LDREQ;
        end
      end
      LDREQ: begin
        a_rd_en   = 1'b1;
        a_rd_addr = i_q;
        state_d   = LOAD;
      end
      LOAD: begin
        pe_load_row = 1'b1;
        state_d     = START;
      end
      START: begin
        pe_start  = 1'b1;
        b_rd_en   = 1'b1;
        b_rd_addr = AW'(32'(j_q));
        s_d       = '0;
        state_d   = STREAM;
      end
      STREAM: begin
        // B read for beat s+1 is issued while beat s is forwarded to the PE
        pe_col_entry = bus.b_rd_data;
        if (s_q != LAST) begin
          b_rd_en   = 1'b1;
          b_rd_addr = AW'((32'(s_q) + 32'd1) * 32'(P) + 32'(j_q));
          s_d       = s_q + 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.pe_done) begin
          c_data_d = bus.pe_total;
          c_row_d  = i_q;
          c_col_d  = j_q;
          state_d  = OUT;
        end
      end
      OUT: begin
        c_valid = 1'b1;
        if (bus.c_ready) begin
          if (j_q != LAST) begin
            j_d     = j_q + 1'b1;
            state_d = START;
          end else if (i_q != LAST) begin
            j_d     = '0;
            i_d     = i_q + 1'b1;
            state_d = LDREQ;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.a_rd_en      = a_rd_en;
  assign bus.a_rd_addr    = a_rd_addr;
  assign bus.b_rd_en      = b_rd_en;
  assign bus.b_rd_addr    = b_rd_addr;
  assign bus.pe_load_row  = pe_load_row;
  assign bus.pe_start     = pe_start;
  assign bus.pe_col_entry = pe_col_entry;
  assign bus.c_valid      = c_valid;
  assign bus.c_data       = c_data_q;
  assign bus.c_row        = c_row_q;
  assign bus.c_col        = c_col_q;
endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb/tb_pe_array_ctrl.sv - directed vectors and corner sequences for pe_array_ctrl at P=2
module tb_pe_array_ctrl;
  localparam int P = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_array_ctrl_if #(.P(P), .DATA_WIDTH(16), .ACCUM_WIDTH(32), .AW(2)) bus ();

  pe_array_ctrl #(.P(P), .DATA_WIDTH(16), .ACCUM_WIDTH(32), .AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [3:0][31:0] c;
  } vec_t;

  typedef struct packed {
    logic [0:0]         r;
    logic [0:0]         c;
    logic signed [31:0] d;
  } res_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   pe_start_cnt = 0;
  int   cur_a [4];
  int   cur_b [4];
  res_t resq [$];
  vec_t vecs [4];

  // Behavioural memories and PE: row data lands one cycle after a_rd_en,
  // pe_done rises two cycles after the last streamed beat
  logic [0:0] a_addr_q;
  int         row [2];
  int         acc;
  int         beat;
  bit         active;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_addr_q      <= '0;
      active        <= 1'b0;
      beat          <= 0;
      acc           <= 0;
      bus.pe_done   <= 1'b0;
      bus.pe_total  <= '0;
      bus.b_rd_data <= '0;
    end else begin
      a_addr_q <= bus.a_rd_addr;
      if (bus.b_rd_en) bus.b_rd_data <= 16'(cur_b[bus.b_rd_addr]);
      if (bus.pe_load_row) begin
        row[0] <= cur_a[2*a_addr_q];
        row[1] <= cur_a[2*a_addr_q+1];
      end
      if (bus.pe_start) begin
        acc         <= 0;
        beat        <= 0;
        active      <= 1'b1;
        bus.pe_done <= 1'b0;
      end else if (active) begin
        if (beat < P) begin
          acc  <= acc + row[beat] * int'(bus.pe_col_entry);
          beat <= beat + 1;
        end else begin
          active       <= 1'b0;
          bus.pe_done  <= 1'b1;
          bus.pe_total <= acc;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.c_valid && bus.c_ready) resq.push_back('{r: bus.c_row, c: bus.c_col, d: bus.c_data});
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (bus.pe_start) pe_start_cnt <= pe_start_cnt + 1;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int a0, a1, a2, a3, b0, b1, b2, b3, c0, c1, c2, c3);
    vec_t v;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
    return v;
  endfunction

  function automatic logic any_out();
    return |{bus.busy, bus.done, bus.err, bus.c_valid, bus.a_rd_en, bus.b_rd_en,
             bus.pe_load_row, bus.pe_start, bus.pe_col_entry, bus.c_data, bus.c_row, bus.c_col};
  endfunction

  task automatic set_mats(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      cur_a[k] = int'(v.a[k]);
      cur_b[k] = int'(v.b[k]);
    end
  endtask

  task automatic pulse_start(output int c0);
    step();
    bus.start = 1'b1;
    c0 = cyc;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      look();
      n++;
    end
    chk({name, "_done_seen"}, longint'(done_cnt != d0), 1);
  endtask

  task automatic check_stream(input vec_t v, input string name);
    chk({name, "_count"}, resq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < resq.size()) begin
        chk($sformatf("%s_row%0d", name, k), resq[k].r, k / 2);
        chk($sformatf("%s_col%0d", name, k), resq[k].c, k % 2);
        chk($sformatf("%s_data%0d", name, k), longint'(resq[k].d), longint'(int'(v.c[k])));
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int c0;
    int d0;
    set_mats(v);
    resq.delete();
    d0 = done_cnt;
    pulse_start(c0);
    wait_done(name, d0);
    chk({name, "_latency"}, done_cyc - c0, 29);
    repeat (3) look();
    chk({name, "_one_done"}, done_cnt, d0 + 1);
    chk({name, "_idle"}, bus.busy, 0);
    check_stream(v, name);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int   c0, d0, sp0, n;
    logic hold_ok, strobe_seen;

    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.pe_err = 1'b0;
    bus.c_ready = 1'b1;

    vecs[0] = mk(1, 2, 3, 4,  5, 6, 7, 8,  19, 22, 43, 50);
    vecs[1] = mk(1, 0, 0, 1,  9, -3, 4, 7,  9, -3, 4, 7);
    vecs[2] = mk(-2, 5, 0, -1,  3, 1, -4, 2,  -26, 8, 4, -2);
    vecs[3] = mk(32767, 32767, -32768, 1,  32767, -32768, 32767, 0,
                 2147352578, -1073709056, -1073676289, 1073741824);

    repeat (3) step();
    chk("reset_outputs_zero", any_out(), 0);
    rst_n = 1'b1;
    look();
    chk("idle_after_reset", any_out(), 0);

    for (int t = 0; t < 4; t++) run_vec(vecs[t], $sformatf("vec%0d", t));

    // c_ready held low at the first result
    set_mats(vecs[0]);
    resq.delete();
    d0 = done_cnt;
    step();
    bus.c_ready = 1'b0;
    pulse_start(c0);
    n = 0;
    while (!bus.c_valid && n < 100) begin
      look();
      n++;
    end
    chk("stall_valid_reached", bus.c_valid, 1);
    sp0 = pe_start_cnt;
    hold_ok = 1'b1;
    strobe_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) look();
      if (!(bus.c_valid && bus.c_data == 19 && bus.c_row == 0 && bus.c_col == 0)) hold_ok = 1'b0;
      if (bus.b_rd_en || bus.pe_start || bus.a_rd_en || bus.pe_load_row) strobe_seen = 1'b1;
    end
    chk("stall_hold", hold_ok, 1);
    chk("stall_no_strobes", strobe_seen, 0);
    chk("stall_no_pe_start", pe_start_cnt, sp0);
    step();
    bus.c_ready = 1'b1;
    wait_done("stall", d0);
    check_stream(vecs[0], "stall");

    // start pulsed during STREAM of the first element is ignored
    set_mats(vecs[2]);
    resq.delete();
    d0 = done_cnt;
    sp0 = pe_start_cnt;
    pulse_start(c0);
    n = 0;
    while (pe_start_cnt == sp0 && n < 50) begin
      look();
      n++;
    end
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("restart", d0);
    repeat (5) look();
    chk("restart_one_done", done_cnt, d0 + 1);
    chk("restart_idle", bus.busy, 0);
    check_stream(vecs[2], "restart");

    // abort in STREAM of element (0,1)
    set_mats(vecs[0]);
    resq.delete();
    d0 = done_cnt;
    sp0 = pe_start_cnt;
    pulse_start(c0);
    n = 0;
    while (pe_start_cnt < sp0 + 2 && n < 80) begin
      look();
      n++;
    end
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.c_valid, 0);
    repeat (40) look();
    chk("abort_no_done", done_cnt, d0);
    chk("abort_results", resq.size(), 1);
    run_vec(vecs[0], "after_abort");

    // single-cycle pe_err during element (1,0)
    set_mats(vecs[1]);
    resq.delete();
    d0 = done_cnt;
    sp0 = pe_start_cnt;
    pulse_start(c0);
    n = 0;
    while (pe_start_cnt < sp0 + 3 && n < 80) begin
      look();
      n++;
    end
    chk("err_before", bus.err, 0);
    step();
    bus.pe_err = 1'b1;
    step();
    bus.pe_err = 1'b0;
    look();
    chk("err_set", bus.err, 1);
    wait_done("err", d0);
    chk("err_at_done", bus.err, 1);
    check_stream(vecs[1], "err");
    resq.delete();
    d0 = done_cnt;
    pulse_start(c0);
    look();
    chk("err_cleared", bus.err, 0);
    wait_done("err_next", d0);
    check_stream(vecs[1], "err_next");

    // reset asserted during WAIT of element (0,0)
    set_mats(vecs[3]);
    resq.delete();
    d0 = done_cnt;
    sp0 = pe_start_cnt;
    pulse_start(c0);
    n = 0;
    while (pe_start_cnt == sp0 && n < 50) begin
      look();
      n++;
    end
    repeat (3) step();
    chk("wait_busy_before_reset", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs_zero", any_out(), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) look();
    chk("reset_mid_no_done", done_cnt, d0);
    chk("reset_mid_no_results", resq.size(), 0);
    run_vec(vecs[3], "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pe_array_ctrl.md
PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 Parameters SHALL be:
- P, default 8, matrix dimension (P x P operands).
- DATA_WIDTH, default 16, operand width.
- ACCUM_WIDTH, default 2*DATA_WIDTH, result width.
- AW, default $clog2(P*P) (minimum 1), B address width.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin C = A*B; accepted only in IDLE.
- abort  in  1  synchronous cancel.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last C element handshakes.
- err  out  1  sticky OR of pe_err while busy; cleared on accepted start.
- a_rd_en  out  1  A-row read strobe.
- a_rd_addr  out  $clog2(P) (minimum 1)  row index i; row data reaches the PE row bus externally one cycle later.
- b_rd_en  out  1  B read strobe.
- b_rd_addr  out  AW  address k*P+j; b_rd_data is valid the next cycle.
- b_rd_data  in  DATA_WIDTH signed  B[k][j].
- pe_load_row  out  1  PE row-buffer load.
- pe_start  out  1  PE dot-product start.
- pe_col_entry  out  DATA_WIDTH signed  operand beat to the PE.
- pe_done  in  1  PE done level.
- pe_err  in  1  PE overflow flag.
- pe_total  in  ACCUM_WIDTH signed  PE result.
- c_valid  out  1  result valid.
- c_ready  in  1  result accept.
- c_data  out  ACCUM_WIDTH signed  C[i][j].
- c_row, c_col  out  $clog2(P) each  result indices.

Function
REQ-003 FSM states SHALL be IDLE, LDREQ, LOAD, START, STREAM, WAIT, OUT.
REQ-004 IDLE: start=1 SHALL clear i, j, err and go to LDREQ. start outside IDLE SHALL be ignored.
REQ-005 LDREQ: a_rd_en=1, a_rd_addr=i for one cycle, then LOAD.
REQ-006 LOAD: pe_load_row=1 for one cycle, then START.
REQ-007 START: pe_start=1, b_rd_en=1, b_rd_addr=j (k=0) for one cycle, then STREAM.
REQ-008 STREAM SHALL last exactly P cycles, with beat counter s=0..P-1:
- pe_col_entry = b_rd_data (the value for k=s).
- b_rd_en=1 with b_rd_addr=(s+1)*P+j while s<P-1.
- Exit to WAIT after s=P-1.
REQ-009 pe_col_entry SHALL be 0 outside STREAM. a_rd_en, b_rd_en, pe_load_row and pe_start SHALL be 0 outside the states named above.
REQ-010 WAIT: on the first cycle pe_done=1, capture pe_total into c_data, i into c_row, j into c_col, then go to OUT. pe_done SHALL NOT be sampled in any other state.
REQ-011 OUT: c_valid=1. c_data, c_row and c_col SHALL stay stable until the c_valid&c_ready cycle. On that handshake:
- j<P-1: j++, go to START (row reused).
- j=P-1 and i<P-1: j=0, i++, go to LDREQ.
- j=P-1 and i=P-1: go to IDLE and pulse done on the next cycle.
REQ-012 c_ready low SHALL stall in OUT indefinitely. No PE or memory strobe SHALL be issued while stalled.
REQ-013 abort=1 in any non-IDLE state SHALL force IDLE on the next edge:
- c_valid deasserted, no done pulse, err retained.
- abort in IDLE has no effect.
- abort has priority over every other transition.
REQ-014 err SHALL set on any busy cycle with pe_err=1 and hold until the next accepted start.
REQ-015 Results SHALL be emitted in row-major order, exactly P*P handshakes per accepted start.
REQ-016 With c_ready=1, each element SHALL take P+4 cycles (START 1, STREAM P, WAIT 2, OUT 1), plus 2 cycles (LDREQ, LOAD) per row.

Reset
REQ-017 rst_n low SHALL asynchronously force:
- state IDLE; i, j, s = 0.
- busy, done, err, c_valid, a_rd_en, b_rd_en, pe_load_row, pe_start = 0.
- pe_col_entry, c_data, c_row, c_col = 0.
REQ-018 Reset asserted mid-operation SHALL abandon the computation with no further handshakes or done pulse.

Verification
REQ-019 P=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], c_ready=1, behavioural PE:
- stream = (0,0,19),(0,1,22),(1,0,43),(1,1,50).
- done pulses once, 28 cycles after start accepted plus 1.
REQ-020 P=2, c_ready low for 5 cycles at the first result: c_valid and c_data=19 hold for all 5 cycles; no b_rd_en or pe_start during the stall; sequence completes unchanged.
REQ-021 start pulsed during STREAM: ignored; exactly 4 results and one done pulse.
REQ-022 abort asserted in STREAM of element (0,1): next cycle busy=0, c_valid=0, no done; a fresh start then produces the full correct 4-result stream.
REQ-023 pe_err=1 for one cycle during element (1,0): err=1 from the next cycle through done; cleared by the next start.
REQ-024 rst_n asserted in WAIT: all outputs 0 immediately; after release, start produces the correct full result.
